// File: rtl/factocon_mul.sv
// Iterative radix-2 shift-add unsigned multiplier for the factorial datapath.
// One product bit per cycle; W+1 edges from start acceptance to op_done.
module factocon_mul #(
   parameter int unsigned W  = 64,
   parameter int unsigned CW = 7
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           op_start,
   input  logic           op_clear,
   input  logic [W-1:0]   multiplier,
   input  logic [W-1:0]   multiplicand,
   output logic [2*W-1:0] result,
   output logic           op_done
);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e         state_q;
   logic [CW-1:0]  count_q;
   logic [W-1:0]   mcand_q;
   logic [2*W-1:0] result_q;
   logic           done_q;
   logic [W:0]     sum;

   // Upper half accumulates; the low half holds the remaining multiplier bits.
   always_comb begin
      sum = {1'b0, result_q[2*W-1:W]} + {1'b0, (result_q[0] ? mcand_q : {W{1'b0}})};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         mcand_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else if (op_clear) begin
         state_q  <= StIdle;
         count_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (op_start) begin
                  mcand_q  <= multiplicand;
                  result_q <= {{W{1'b0}}, multiplier};
                  count_q  <= '0;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               result_q <= {sum, result_q[W-1:1]};
               count_q  <= count_q + 1'b1;
               if (count_q == CW'(W - 1)) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               // Held until op_clear; op_start must not retrigger.
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign result  = result_q;
   assign op_done = done_q;

endmodule

// File: tb/tb_factocon_mul.sv
// Directed self-checking bench for factocon_mul with W=64.
module tb_factocon_mul;

   localparam int unsigned W = 64;

   logic           clk;
   logic           reset_n;
   logic           op_start;
   logic           op_clear;
   logic [W-1:0]   multiplier;
   logic [W-1:0]   multiplicand;
   logic [2*W-1:0] result;
   logic           op_done;

   int pass_cnt;
   int total_cnt;

   factocon_mul #(.W(W), .CW(7)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .multiplier  (multiplier),
      .multiplicand(multiplicand),
      .result      (result),
      .op_done     (op_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns #1 after the accept edge E0.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      multiplier   = a;
      multiplicand = b;
      op_start     = 1'b1;
      op_clear     = 1'b0;
      wait_edges(1);
   endtask

   task automatic do_clear();
      op_start = 1'b0;
      op_clear = 1'b1;
      wait_edges(1);
      op_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      op_start = 1'b0;
      op_clear = 1'b0;
      multiplier   = '0;
      multiplicand = '0;
      #12;
      total_cnt++;
      if (result !== '0 || op_done !== 1'b0)
         $display("FAIL reset: result=%h op_done=%b, required 0/0", result, op_done);
      else pass_cnt++;
      reset_n = 1'b1;
      wait_edges(2);
      total_cnt++;
      if (result !== '0 || op_done !== 1'b0)
         $display("FAIL reset_release: result=%h op_done=%b, required 0/0", result, op_done);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      start_op(64'd5, 64'd4);
      wait_edges(63);
      total_cnt++;
      if (op_done !== 1'b0)
         $display("FAIL basic_early_done: op_done=%b at E0+63, required 0", op_done);
      else pass_cnt++;
      wait_edges(1);
      total_cnt++;
      if (op_done !== 1'b1 || result !== 128'd20)
         $display("FAIL basic: result=%0d op_done=%b, required 20/1", result, op_done);
      else pass_cnt++;
      multiplier   = 64'd9;
      multiplicand = 64'd9;
      for (int i = 0; i < 10; i++) begin
         wait_edges(1);
         total_cnt++;
         if (op_done !== 1'b1 || result !== 128'd20)
            $display("FAIL basic_hold[%0d]: result=%0d op_done=%b, required 20/1",
                     i, result, op_done);
         else pass_cnt++;
      end
      do_clear();
   endtask

   task automatic test_max();
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_edges(63);
      total_cnt++;
      if (op_done !== 1'b0)
         $display("FAIL max_early_done: op_done=%b, required 0", op_done);
      else pass_cnt++;
      wait_edges(1);
      total_cnt++;
      if (op_done !== 1'b1 || result !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001)
         $display("FAIL max: result=%h op_done=%b, required fffffffffffffffe0000000000000001/1",
                  result, op_done);
      else pass_cnt++;
      do_clear();
   endtask

   task automatic test_zero_one();
      start_op(64'd0, 64'd123);
      wait_edges(63);
      total_cnt++;
      if (op_done !== 1'b0)
         $display("FAIL zero_early_done: op_done=%b, required 0", op_done);
      else pass_cnt++;
      wait_edges(1);
      total_cnt++;
      if (op_done !== 1'b1 || result !== '0)
         $display("FAIL zero: result=%h op_done=%b, required 0/1", result, op_done);
      else pass_cnt++;
      do_clear();
      start_op(64'd1, 64'h8000_0000_0000_0000);
      wait_edges(64);
      total_cnt++;
      if (op_done !== 1'b1 || result !== 128'h8000_0000_0000_0000)
         $display("FAIL one: result=%h op_done=%b, required 00000000000000008000000000000000/1",
                  result, op_done);
      else pass_cnt++;
      do_clear();
   endtask

   task automatic test_clear_mid();
      start_op(64'd1234567, 64'd7654321);
      wait_edges(29);
      op_clear = 1'b1;
      wait_edges(1);
      total_cnt++;
      if (op_done !== 1'b0 || result !== '0)
         $display("FAIL clear_mid: result=%h op_done=%b, required 0/0", result, op_done);
      else pass_cnt++;
      start_op(64'd6, 64'd5);
      wait_edges(64);
      total_cnt++;
      if (op_done !== 1'b1 || result !== 128'd30)
         $display("FAIL clear_restart: result=%0d op_done=%b, required 30/1", result, op_done);
      else pass_cnt++;
      do_clear();
   endtask

   task automatic test_clear_start_and_operands();
      multiplier   = 64'd11;
      multiplicand = 64'd13;
      op_start = 1'b1;
      op_clear = 1'b1;
      wait_edges(1);
      op_start = 1'b0;
      op_clear = 1'b0;
      wait_edges(70);
      total_cnt++;
      if (op_done !== 1'b0 || result !== '0)
         $display("FAIL clear_start: result=%h op_done=%b, required 0/0", result, op_done);
      else pass_cnt++;
      start_op(64'd7, 64'd3);
      wait_edges(10);
      multiplicand = 64'd99;
      multiplier   = 64'd55;
      wait_edges(54);
      total_cnt++;
      if (op_done !== 1'b1 || result !== 128'd21)
         $display("FAIL operand_change: result=%0d op_done=%b, required 21/1", result, op_done);
      else pass_cnt++;
      do_clear();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   a_vec [4];
      logic [W-1:0]   b_vec [4];
      logic [2*W-1:0] exp_vec [4];
      a_vec   = '{64'd5, 64'd20, 64'd60, 64'd120};
      b_vec   = '{64'd4, 64'd3, 64'd2, 64'd1};
      exp_vec = '{128'd20, 128'd60, 128'd120, 128'd120};
      for (int i = 0; i < 4; i++) begin
         start_op(a_vec[i], b_vec[i]);
         wait_edges(64);
         total_cnt++;
         if (op_done !== 1'b1 || result !== exp_vec[i])
            $display("FAIL chain[%0d]: result=%0d op_done=%b, required %0d/1",
                     i, result, op_done, exp_vec[i]);
         else pass_cnt++;
         do_clear();
      end
   endtask

   task automatic test_async_reset();
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_edges(20);
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if (op_done !== 1'b0 || result !== '0)
         $display("FAIL async_reset: result=%h op_done=%b, required 0/0", result, op_done);
      else pass_cnt++;
      op_start = 1'b0;
      #10;
      reset_n = 1'b1;
      wait_edges(70);
      total_cnt++;
      if (op_done !== 1'b0 || result !== '0)
         $display("FAIL async_reset_idle: result=%h op_done=%b, required 0/0", result, op_done);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_basic();
      test_max();
      test_zero_one();
      test_clear_mid();
      test_clear_start_and_operands();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/factocon_mul.md
Name: factocon_mul

Overview:
- Iterative unsigned shift-add multiplier consumed by the factorial controller's datapath.
- Receives op_start/op_clear and the 64-bit multiplier/multiplicand from the controller's registered next-state outputs.
- Returns a 128-bit product with a done flag; the controller feeds the product back as the next multiplier.
- One product bit per cycle, radix-2.

Parameters:
- W, 64: operand width; result width is 2*W.
- CW, 7: iteration counter width; must hold the value W.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op_start  input  1  level start request; a rising-level start is accepted only in IDLE.
- op_clear  input  1  synchronous clear; returns the block to IDLE and zeroes the result.
- multiplier  input  W  operand A, latched when a start is accepted.
- multiplicand  input  W  operand B, latched when a start is accepted.
- result  output  2*W  product register; valid while op_done=1.
- op_done  output  1  high when the product is complete.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, result=0, op_done=0, count=0, mcand_q=0. Reset is honoured at any time, including mid-operation, with no partial product retained.
- States: IDLE, EXEC, DONE.
- Priority at each rising edge: reset_n, then op_clear, then op_start.
- op_clear=1 in any state:
  - next state IDLE; result=0, op_done=0, count=0.
  - A simultaneous op_start is ignored.
- IDLE with op_start=1:
  - mcand_q <= multiplicand; result <= {W'b0, multiplier}; count <= 0.
  - next state EXEC.
- IDLE with op_start=0: hold.
- EXEC, one step per edge:
  - sum (W+1 bits) = result[2W-1:W] + (result[0] ? mcand_q : 0).
  - result <= {sum, result[W-1:1]}, a right shift with the carry entering the MSB.
  - count <= count+1.
  - When count==W-1 on this edge: next state DONE, op_done <= 1.
- Latency: start accepted at edge E0; op_done and the final result are visible after edge E0+W (W+1 edges inclusive of the accept edge).
- Operand inputs are don't-care during EXEC and DONE; the latched copies are used.
- op_start is ignored in EXEC and DONE. The controller holds op_start high through its CALC state, and this must not retrigger. A new operation requires op_clear, then op_start while in IDLE.
- DONE: result and op_done held stable indefinitely until op_clear or reset.
- Arithmetic:
  - Unsigned only. Full 2W-bit product, no truncation or overflow flag.
  - Operand 0 yields result 0 after the full W cycles. There is no early termination, so latency is data-independent.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic (W=64): reset, then op_start with multiplier=5, multiplicand=4 -> after 65 edges op_done=1 and result=20; result and op_done stay stable for 10 further cycles with op_start held high (no retrigger).
- Max operands: multiplier=multiplicand=64'hFFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, op_done=1 at edge E0+64.
- Zero and one: multiplier=0, multiplicand=123 -> result=0 with op_done at E0+64. multiplier=1, multiplicand=64'h8000_0000_0000_0000 -> result=128'h8000_0000_0000_0000.
- Clear mid-operation: op_clear at edge E0+30 -> state IDLE, result=0, op_done=0 on the next cycle. Then op_clear=0, op_start with multiplier=6, multiplicand=5 -> result=30 after 65 edges.
- Simultaneous op_clear and op_start in IDLE -> no start, result=0. Operand change during EXEC (multiplicand switched to 99 at E0+10, start operands 7 and 3) -> result=21.
- Factorial chain as the controller drives it: 5*4, clear, 20*3, clear, 60*2, clear, 120*1 -> successive results 20, 60, 120, 120.
- Async reset: reset_n low mid-EXEC, asserted between clock edges -> result=0 and op_done=0 immediately, before the next edge.
